md_pad_engine: RTL
==================

// Module: md_pad_engine
// PURPOSE
//  Merkle-Damgard message padder for the hash datapath. Given a message already in
//  byte-wide scratch memory at base_addr, writes the 0x80 marker, zero fill and the
//  bit-length field directly into that memory through a ready/valid write port.
//  Supports multi-block padding when the tail overflows, with a programmable
//  block size and length-field size. Sits between message loader and compression core.
// PARAMETERS
//  DATA_WIDTH   8   memory data width; fixed byte lane, must be 8
//  ADDR_WIDTH   10  memory address width
//  BLOCK_BYTES  64  hash block size in bytes; power of 2, >= LEN_BYTES+2
//  LEN_BYTES    8   length-field size in bytes (8 for SHA-256, 16 for SHA-512)
//  MSGLEN_WIDTH 16  width of msg_len (bytes); requires MSGLEN_WIDTH+3 <= 8*LEN_BYTES
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             asynchronous, active-low reset
//  start      in   1             1-cycle request; sampled only in IDLE
//  base_addr  in   ADDR_WIDTH    byte address of message byte 0; latched on start
//  msg_len    in   MSGLEN_WIDTH  message length in bytes; latched on start
//  mem_addr   out  ADDR_WIDTH    write address
//  mem_wdata  out  DATA_WIDTH    write data
//  mem_we     out  1             write valid
//  mem_ready  in   1             write accepted when mem_we && mem_ready at clk edge
//  busy       out  1             high from cycle after start until done
//  done       out  1             1-cycle pulse after last accepted write
//  num_blocks out  MSGLEN_WIDTH  total padded blocks; valid from done until next start
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; mem_we=0, busy=0, done=0, mem_addr=0,
//    mem_wdata=0, num_blocks=0. rst low mid-operation drops mem_we immediately;
//    in-flight write is abandoned and not retried.
//  - T = ceil((msg_len+1+LEN_BYTES)/BLOCK_BYTES)*BLOCK_BYTES; num_blocks=T/BLOCK_BYTES.
//    Writes cover offsets msg_len..T-1 in ascending order, one per accepted cycle.
//  - mem_addr = base_addr + offset, modulo 2^ADDR_WIDTH (wraps silently).
//  - L = msg_len*8, zero-extended to 8*LEN_BYTES bits, computed at latch.
//  - FSM: IDLE -start-> CALC (1 cycle: latch, compute T/L) -> MARK
//    MARK: data 0x80 at offset msg_len; on accept -> ZERO if offset+1 < T-LEN_BYTES
//      else LEN.
//    ZERO: data 0x00; on accept at offset T-LEN_BYTES-1 -> LEN.
//    LEN: data = byte k of L (k=0 at offset T-LEN_BYTES); big-endian, MSB first;
//      on accept at offset T-1 -> DONE.
//    DONE: done=1, busy=0 for one cycle -> IDLE.
//  - Handshake: while mem_we=1, mem_addr/mem_wdata held stable until accepted;
//    mem_we deasserts in CALC, DONE and IDLE only. No combinational path
//    mem_ready -> mem_we.
//  - Min latency (mem_ready tied 1): start at cycle 0, first write presented
//    cycle 2, done pulse at cycle 2+(T-msg_len).
//  - start while busy or in DONE: ignored. start in cycle after done: accepted.
//  - msg_len%BLOCK_BYTES == BLOCK_BYTES-LEN_BYTES-1: MARK -> LEN directly, no ZERO.
//  - msg_len%BLOCK_BYTES > BLOCK_BYTES-LEN_BYTES-1: extra block appended.
// CONFIGURATION
//  PAD_LEN_LITTLE_ENDIAN_EN defined: length field written LSB first (MD5 style);
//   byte k of the field = L[8k+7:8k]. All other behaviour identical.
//  Not defined: big-endian length field (SHA-1/SHA-2 style), as above.
// TESTING
//  1. msg_len=3, base=0, ready=1 -> 61 writes; [3]=0x80, [4..55]=0,
//     [56..62]=0, [63]=0x18; num_blocks=1; done at cycle 63.
//  2. msg_len=55 -> 9 writes: [55]=0x80, [56..63]=00..00,01,B8; no zero writes.
//  3. msg_len=56 -> 72 writes to 56..127; [120..127]=..01,C0; num_blocks=2.
//  4. msg_len=0, base=0x3F0 -> 64 writes, addresses wrap 0x3FF -> 0x000;
//     [0x3F0]=0x80, last write at 0x02F = 0x00.
//  5. msg_len=3, mem_ready low 5 cycles mid-ZERO and on last LEN byte ->
//     addr/data stable while stalled; no skipped or duplicated writes;
//     start pulses while busy ignored.
//  6. rst low during ZERO -> mem_we/busy 0 same cycle; after release, new
//     start runs clean; with PAD_LEN_LITTLE_ENDIAN_EN, msg_len=3 -> [56]=0x18,
//     [57..63]=0.

Source files
------------

// File: rtl/md_pad_engine.sv
// Merkle-Damgard padder: writes the 0x80 marker, the zero fill and the bit-length field after a message held in byte memory.
// Optional PAD_LEN_LITTLE_ENDIAN_EN: the length field is written LSB first (MD5 style) instead of MSB first.
module md_pad_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int BLOCK_BYTES  = 64,
    parameter int LEN_BYTES    = 8,
    parameter int MSGLEN_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [MSGLEN_WIDTH-1:0] msg_len,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done,
    output logic [MSGLEN_WIDTH-1:0] num_blocks
);

    localparam int OW  = MSGLEN_WIDTH + 2;
    localparam int LW  = 8 * LEN_BYTES;
    localparam int BSH = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_MARK,
        S_ZERO,
        S_LEN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [MSGLEN_WIDTH-1:0] r_len;
    logic [OW-1:0]           r_off;
    logic [OW-1:0]           r_total;
    logic [LW-1:0]           r_bits;
    logic [MSGLEN_WIDTH-1:0] r_nblk;

    logic          w_accept;
    logic [OW-1:0] w_sum;
    logic [OW-1:0] w_nblk_full;
    logic [OW-1:0] w_total;
    logic [OW-1:0] w_len_start;
    logic [OW-1:0] w_off_nx;

    assign w_sum       = OW'(r_len) + OW'(LEN_BYTES + BLOCK_BYTES);
    assign w_nblk_full = w_sum >> BSH;
    assign w_total     = w_nblk_full << BSH;
    assign w_len_start = r_total - OW'(LEN_BYTES);
    assign w_off_nx    = r_off + OW'(1);
    assign w_accept    = mem_we && mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_off   <= '0;
            r_total <= '0;
            r_bits  <= '0;
            r_nblk  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_len  <= msg_len;
                    end
                end
                S_CALC: begin
                    r_off   <= OW'(r_len);
                    r_total <= w_total;
                    r_nblk  <= MSGLEN_WIDTH'(w_nblk_full);
                    r_bits  <= LW'(r_len) << 3;
                end
                S_MARK, S_ZERO: begin
                    if (w_accept) r_off <= w_off_nx;
                end
                S_LEN: begin
                    // The next length byte always sits at the outgoing end of r_bits.
                    if (w_accept) begin
                        r_off <= w_off_nx;
`ifdef PAD_LEN_LITTLE_ENDIAN_EN
                        r_bits <= {8'h00, r_bits[LW-1:8]};
`else
                        r_bits <= {r_bits[LW-9:0], 8'h00};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_CALC;
            S_CALC: w_next = S_MARK;
            S_MARK: begin
                if (w_accept) w_next = (w_off_nx < w_len_start) ? S_ZERO : S_LEN;
            end
            S_ZERO: begin
                if (w_accept && (r_off == w_len_start - OW'(1))) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_accept && (r_off == r_total - OW'(1))) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = (r_state == S_MARK) || (r_state == S_ZERO) || (r_state == S_LEN);
        busy      = (r_state == S_CALC) || mem_we;
        done      = (r_state == S_DONE);
        mem_addr  = r_base + ADDR_WIDTH'(r_off);
        mem_wdata = '0;
        if (r_state == S_MARK) begin
            mem_wdata = DATA_WIDTH'(8'h80);
        end else if (r_state == S_LEN) begin
`ifdef PAD_LEN_LITTLE_ENDIAN_EN
            mem_wdata = DATA_WIDTH'(r_bits[7:0]);
`else
            mem_wdata = DATA_WIDTH'(r_bits[LW-1 -: 8]);
`endif
        end
    end

    assign num_blocks = r_nblk;

endmodule
